// File: rtl/oci_dct_trace_capture.sv
// Debug trace capture: records dct_buffer whenever dct_count changes while capturing; show-ahead read port.
// Latency: entry visible one cycle after the count change; reads are valid/ready, drop-or-overwrite when full.
module oci_dct_trace_capture #(
  parameter int ENTRY_W      = 30,
  parameter int COUNT_W      = 4,
  parameter int DEPTH        = 16,
  parameter int STOP_ON_FULL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [ENTRY_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam bit OVERWRITE = (STOP_ON_FULL == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] prev_count;
  logic               push, pop, full, wr_en, lose;

  assign full     = (level == FULL_LVL);
  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];
  assign state    = state_q;
  assign push     = (state_q == CAPTURE) && (dct_count != prev_count);
  assign pop      = rd_valid && rd_ready;
  // A full buffer still accepts a write when a pop frees the head in the same cycle.
  assign lose     = push && full && !pop;
  assign wr_en    = push && (!lose || OVERWRITE);

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr] <= dct_buffer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      prev_count <= '0;
      done       <= 1'b0;
    end else begin
      prev_count <= dct_count;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      // Overwrite mode discards the oldest entry by stepping the read pointer past it.
      if (pop || (lose && OVERWRITE)) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop && !full)  level <= level + LW'(1);
      else if (pop && !wr_en)      level <= level - LW'(1);
      if (lose) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (test_has_ended) begin
        state_q <= DONE;
        done    <= 1'b1;
      end else begin
        case (state_q)
          IDLE:    if (arm) state_q <= CAPTURE;
          CAPTURE: if (test_ending) state_q <= DRAIN;
          DRAIN:   if (level == '0 && !pop) begin
            state_q <= DONE;
            done    <= 1'b1;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oci_dct_trace_capture.sv
// Directed bench: two instances (drop mode and overwrite mode) share stimulus, separate read strobes.
module tb_oci_dct_trace_capture;
  logic        clk = 1'b0;
  logic        reset, arm, test_ending, test_has_ended, s_ready, o_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        s_valid, o_valid, s_ovf, o_ovf, s_done, o_done;
  logic [29:0] s_data, o_data;
  logic [4:0]  s_level, o_level;
  logic [15:0] s_drop, o_drop;
  logic [1:0]  s_state, o_state;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  oci_dct_trace_capture #(.ENTRY_W(30), .COUNT_W(4), .DEPTH(16), .STOP_ON_FULL(1)) u_stop (
    .clk(clk), .reset(reset), .arm(arm), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(s_ready),
    .rd_valid(s_valid), .rd_data(s_data), .level(s_level), .overflow(s_ovf),
    .drop_count(s_drop), .state(s_state), .done(s_done));

  oci_dct_trace_capture #(.ENTRY_W(30), .COUNT_W(4), .DEPTH(16), .STOP_ON_FULL(0)) u_ovw (
    .clk(clk), .reset(reset), .arm(arm), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(o_ready),
    .rd_valid(o_valid), .rd_data(o_data), .level(o_level), .overflow(o_ovf),
    .drop_count(o_drop), .state(o_state), .done(o_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    s_ready = 1'b0; o_ready = 1'b0; dct_count = 4'd0; dct_buffer = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic push_n(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      dct_count = 4'(i); dct_buffer = 30'(i); tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_state !== 2'd0) $display("FAIL reset_state got %0d want 0", s_state); else passes++;
    checks++; if (s_level !== 5'd0) $display("FAIL reset_level got %0d want 0", s_level); else passes++;
    checks++; if (s_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", s_valid); else passes++;
    checks++; if (s_ovf !== 1'b0) $display("FAIL reset_overflow got %b want 0", s_ovf); else passes++;
    checks++; if (s_drop !== 16'd0) $display("FAIL reset_drop got %0d want 0", s_drop); else passes++;
    checks++; if (s_done !== 1'b0) $display("FAIL reset_done got %b want 0", s_done); else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    do_arm();
    checks++; if (s_state !== 2'd1) $display("FAIL basic_armed got %0d want 1", s_state); else passes++;
    checks++; if (s_level !== 5'd0) $display("FAIL basic_arm_nopush got %0d want 0", s_level); else passes++;
    dct_count = 4'd1; dct_buffer = 30'h0AA; tick();
    dct_count = 4'd2; dct_buffer = 30'h0BB; tick();
    checks++; if (s_level !== 5'd2) $display("FAIL basic_level got %0d want 2", s_level); else passes++;
    s_ready = 1'b1;
    checks++; if (s_data !== 30'h0AA) $display("FAIL basic_rd0 got %h want 0aa", s_data); else passes++;
    tick();
    checks++; if (s_data !== 30'h0BB) $display("FAIL basic_rd1 got %h want 0bb", s_data); else passes++;
    checks++; if (s_level !== 5'd1) $display("FAIL basic_level1 got %0d want 1", s_level); else passes++;
    tick();
    checks++; if (s_valid !== 1'b0) $display("FAIL basic_empty got %b want 0", s_valid); else passes++;
    s_ready = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    do_arm();
    push_n(1, 18);
    checks++; if (s_level !== 5'd16) $display("FAIL stop_level got %0d want 16", s_level); else passes++;
    checks++; if (s_ovf !== 1'b1) $display("FAIL stop_overflow got %b want 1", s_ovf); else passes++;
    checks++; if (s_drop !== 16'd2) $display("FAIL stop_drop got %0d want 2", s_drop); else passes++;
    checks++; if (o_level !== 5'd16) $display("FAIL ovw_level got %0d want 16", o_level); else passes++;
    checks++; if (o_ovf !== 1'b1) $display("FAIL ovw_overflow got %b want 1", o_ovf); else passes++;
    checks++; if (o_drop !== 16'd2) $display("FAIL ovw_drop got %0d want 2", o_drop); else passes++;
    s_ready = 1'b1; o_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (s_data !== 30'(i + 1)) $display("FAIL stop_rd%0d got %0d want %0d", i, s_data, i + 1); else passes++;
      checks++; if (o_data !== 30'(i + 3)) $display("FAIL ovw_rd%0d got %0d want %0d", i, o_data, i + 3); else passes++;
      tick();
    end
    checks++; if (s_valid !== 1'b0) $display("FAIL stop_drained got %b want 0", s_valid); else passes++;
    s_ready = 1'b0; o_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    do_arm();
    push_n(1, 16);
    checks++; if (s_level !== 5'd16) $display("FAIL simul_full got %0d want 16", s_level); else passes++;
    s_ready = 1'b1; dct_count = 4'd1; dct_buffer = 30'h55; tick();
    s_ready = 1'b0;
    checks++; if (s_level !== 5'd16) $display("FAIL simul_level got %0d want 16", s_level); else passes++;
    checks++; if (s_ovf !== 1'b0) $display("FAIL simul_overflow got %b want 0", s_ovf); else passes++;
    checks++; if (s_data !== 30'd2) $display("FAIL simul_head got %0d want 2", s_data); else passes++;
    do_reset();
    do_arm();
    test_ending = 1'b1; test_has_ended = 1'b1; tick();
    test_ending = 1'b0; test_has_ended = 1'b0;
    checks++; if (s_state !== 2'd3) $display("FAIL abort_state got %0d want 3", s_state); else passes++;
    checks++; if (s_done !== 1'b1) $display("FAIL abort_done got %b want 1", s_done); else passes++;
  endtask

  task automatic test_drain();
    do_reset();
    do_arm();
    push_n(1, 3);
    test_ending = 1'b1; tick(); test_ending = 1'b0;
    checks++; if (s_state !== 2'd2) $display("FAIL drain_state got %0d want 2", s_state); else passes++;
    dct_count = 4'd9; tick();
    checks++; if (s_level !== 5'd3) $display("FAIL drain_nopush got %0d want 3", s_level); else passes++;
    s_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (s_data !== 30'(i + 1)) $display("FAIL drain_rd%0d got %0d want %0d", i, s_data, i + 1); else passes++;
      tick();
    end
    s_ready = 1'b0;
    checks++; if (s_state !== 2'd2) $display("FAIL drain_still got %0d want 2", s_state); else passes++;
    tick();
    checks++; if (s_state !== 2'd3) $display("FAIL drain_done_state got %0d want 3", s_state); else passes++;
    checks++; if (s_done !== 1'b1) $display("FAIL drain_done got %b want 1", s_done); else passes++;
    do_arm();
    checks++; if (s_state !== 2'd3) $display("FAIL done_arm_ignored got %0d want 3", s_state); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_arm();
    push_n(1, 5);
    checks++; if (s_level !== 5'd5) $display("FAIL mid_level_pre got %0d want 5", s_level); else passes++;
    reset = 1'b1; dct_count = 4'd7; tick(); reset = 1'b0;
    checks++; if (s_state !== 2'd0) $display("FAIL mid_state got %0d want 0", s_state); else passes++;
    checks++; if (s_level !== 5'd0) $display("FAIL mid_level got %0d want 0", s_level); else passes++;
    checks++; if (s_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", s_valid); else passes++;
    checks++; if (s_drop !== 16'd0) $display("FAIL mid_drop got %0d want 0", s_drop); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simultaneous();
    test_drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/oci_dct_trace_capture.md
OCI_DCT_TRACE_CAPTURE -- requirements
Module: oci_dct_trace_capture

Interface
REQ-001 SHALL have parameter ENTRY_W, default 30, width of one debug trace (DCT) entry.
REQ-002 SHALL have parameter COUNT_W, default 4, width of the DCT sequence count.
REQ-003 SHALL have parameter DEPTH, default 16, trace buffer entries; power of 2, at least 2.
REQ-004 SHALL have parameter STOP_ON_FULL, default 1; 1 = drop new entries when full, 0 = overwrite oldest.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port arm  input  1  one-cycle pulse that starts capture.
REQ-008 SHALL have port dct_buffer  input  ENTRY_W  trace entry data.
REQ-009 SHALL have port dct_count  input  COUNT_W  trace sequence count; any change marks a new entry.
REQ-010 SHALL have port test_ending  input  1  stop capture, then drain.
REQ-011 SHALL have port test_has_ended  input  1  abort to DONE.
REQ-012 SHALL have port rd_ready  input  1  consumer accepts head entry.
REQ-013 SHALL have port rd_valid  output  1  head entry available.
REQ-014 SHALL have port rd_data  output  ENTRY_W  head entry (show-ahead).
REQ-015 SHALL have port level  output  clog2(DEPTH+1)  entries stored.
REQ-016 SHALL have port overflow  output  1  sticky flag; at least one entry lost or overwritten.
REQ-017 SHALL have port drop_count  output  16  lost or overwritten entries, saturating at 0xFFFF.
REQ-018 SHALL have port state  output  2  encoding IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-019 SHALL have port done  output  1  high while state is DONE.

Function
REQ-020 SHALL register dct_count every cycle into prev_count; push event = (state==CAPTURE) and (dct_count != prev_count).
REQ-021 SHALL write dct_buffer into the buffer in the cycle after the push event; at most one write per cycle; capture latency is 1 cycle.
REQ-022 SHALL set rd_valid = (level != 0); rd_data SHALL show the oldest entry combinationally from the buffer.
REQ-023 SHALL count a pop when rd_valid and rd_ready are both high at a rising edge; the read pointer advances by 1, modulo DEPTH.
REQ-024 SHALL treat a simultaneous push and pop at any level as one write plus one read, with level unchanged; no overflow, even when full.
REQ-025 SHALL handle a push while full without a pop as follows when STOP_ON_FULL=1: discard the entry, set overflow, increment drop_count.
REQ-026 SHALL handle a push while full without a pop as follows when STOP_ON_FULL=0: write the entry, advance the read pointer, keep level=DEPTH, set overflow, increment drop_count.
REQ-027 SHALL apply the following transition from IDLE: on arm, go to CAPTURE; prev_count SHALL be loaded with the current dct_count, so arming alone makes no push.
REQ-028 SHALL apply the following transition from CAPTURE: on test_ending, go to DRAIN; a push event in the same cycle SHALL still be captured.
REQ-029 SHALL apply the following transition from DRAIN: go to DONE when level==0 and no pop is pending; pops SHALL continue in DRAIN.
REQ-030 SHALL, on test_has_ended in any state, go to DONE next cycle; test_has_ended SHALL win over test_ending and arm.
REQ-031 SHALL leave DONE only on reset; reads SHALL remain allowed in DONE and pushes SHALL NOT occur.
REQ-032 SHALL ignore arm in every state except IDLE.
REQ-033 SHALL compute pointers with log2(DEPTH) bits and wrap naturally; level SHALL never exceed DEPTH.

Reset
REQ-034 SHALL, on reset at any cycle, take effect at the next edge: state=IDLE, pointers=0, level=0, rd_valid=0, overflow=0, drop_count=0, prev_count=0, done=0.
REQ-035 SHALL give reset priority over every other input; data in flight at reset SHALL be discarded.
REQ-036 SHALL leave buffer RAM contents unspecified after reset; rd_data is don't-care while rd_valid=0.

Verification
REQ-037 Basic: arm; dct_count steps 0->1->2 with dct_buffer 0x0AA, 0x0BB; rd_ready=0 -> level=2; then rd_ready=1 -> reads 0x0AA then 0x0BB, rd_valid drops.
REQ-038 Full, stop mode: DEPTH=16, STOP_ON_FULL=1, 18 count changes, no reads -> level=16, overflow=1, drop_count=2, entries 1..16 read back in order.
REQ-039 Full, overwrite mode: STOP_ON_FULL=0, same stimulus -> level=16, drop_count=2, first read returns entry 3.
REQ-040 Simultaneous events: full buffer, push and pop in the same cycle -> level stays 16, overflow stays 0; separately, test_ending and test_has_ended together -> DONE next cycle.
REQ-041 Drain: 3 entries stored, test_ending pulse -> DRAIN; count changes ignored; after 3 pops -> DONE, done=1.
REQ-042 Reset mid-operation: reset asserted with level=5 while in CAPTURE -> next cycle state=0, level=0, rd_valid=0, drop_count=0.
